// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer
// Synchronises and debounces a one-hot keypad. Accepted keys build an
// N_BYTES ASCII plaintext buffer for the LEA core. Digits append a byte,
// '*' (key N_KEYS-2) erases the last byte, and '#' (key N_KEYS-1) freezes
// the entry and raises CHK. Every buffer edit produces a one-cycle echo
// strobe, which lets the LCD writer redraw a single character cell.
//
// Build option: define KEYPAD_MASK_EN to echo '*' (8'h2A) for every digit.
// The buffer itself always stores the true ASCII digit.
module keypad_entry_buffer #(
  parameter int         N_KEYS   = 12,
  parameter int         N_BYTES  = 16,
  parameter int         DEBOUNCE = 4,
  parameter logic [7:0] PAD      = 8'h20
) (
  input  logic                                            CLK,
  input  logic                                            RST,
  input  logic [N_KEYS-1:0]                               Keypad,
  output logic [8*N_BYTES-1:0]                            PlainText,
  output logic [$clog2(N_BYTES+1)-1:0]                    Count,
  output logic                                            Full,
  output logic                                            CHK,
  output logic                                            Echo_Valid,
  output logic [7:0]                                      Echo_Data,
  output logic [((N_BYTES > 1) ? $clog2(N_BYTES) : 1)-1:0] Echo_Pos
);

  localparam int CNT_W  = $clog2(N_BYTES + 1);
  localparam int POS_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int KEY_BS = N_KEYS - 2;
  localparam int KEY_EN = N_KEYS - 1;
  localparam logic [N_KEYS-1:0] KEY_ONE  = N_KEYS'(1);
  localparam logic [7:0]        ASCII_0  = 8'h30;
  localparam logic [7:0]        MASK_CHR = 8'h2A;
`ifdef KEYPAD_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_ACT,
    S_HELD,
    S_RELEASE
  } state_t;

  // A vector is one-hot when it is nonzero and clearing its lowest set bit leaves nothing.
  function automatic logic is_one_hot(input logic [N_KEYS-1:0] v);
    return (v != '0) && ((v & (v - KEY_ONE)) == '0);
  endfunction

  // Index of the set bit of a one-hot key vector.
  function automatic logic [4:0] key_index(input logic [N_KEYS-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  logic [N_KEYS-1:0]    k_s1_q, k_s2_q;
  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           cnt_inc;
  logic [N_KEYS-1:0]    key_q, key_d;

  logic [8*N_BYTES-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 chk_q, chk_d;
  logic                 echo_valid_q, echo_valid_d;
  logic [7:0]           echo_data_q, echo_data_d;
  logic [POS_W-1:0]     echo_pos_q, echo_pos_d;

  logic [4:0]           key_idx;
  logic [7:0]           digit_char;
  logic [7:0]           digit_echo;
  logic [8*N_BYTES-1:0] base_buf;
  logic [CNT_W-1:0]     base_cnt;
  logic [CNT_W-1:0]     bs_idx;

  // The counter never passes DEBOUNCE (at most 255), so the increment cannot wrap.
  assign cnt_inc    = cnt_q + 8'd1;
  assign key_idx    = key_index(key_q);
  assign digit_char = ASCII_0 + {3'b000, key_idx};
  assign digit_echo = MASK_EN ? MASK_CHR : digit_char;
  // A digit typed after enter starts from an empty buffer in the same cycle.
  assign base_buf   = chk_q ? {N_BYTES{PAD}} : buf_q;
  assign base_cnt   = chk_q ? '0 : count_q;
  assign bs_idx     = count_q - CNT_W'(1);

  // Two-flop synchroniser for the raw keypad lines.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      k_s1_q <= '0;
      k_s2_q <= '0;
    end else begin
      k_s1_q <= Keypad;
      k_s2_q <= k_s1_q;
    end
  end

  // Debounce FSM state, stability counter and latched key.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  // Debounce next-state logic. Presses and releases must each stay stable for DEBOUNCE cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_one_hot(k_s2_q)) begin
          state_d = S_PRESS;
          cnt_d   = 8'd1;
          key_d   = k_s2_q;
        end
      end
      S_PRESS: begin
        if (k_s2_q == key_q) begin
          cnt_d = cnt_inc;
          if (int'(cnt_inc) >= DEBOUNCE) state_d = S_ACT;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_ACT: begin
        state_d = S_HELD;
        cnt_d   = '0;
      end
      S_HELD: begin
        // Any nonzero pattern, multi-hot included, counts as still held.
        if (k_s2_q == '0) begin
          state_d = S_RELEASE;
          cnt_d   = 8'd1;
        end
      end
      S_RELEASE: begin
        if (k_s2_q == '0) begin
          cnt_d = cnt_inc;
          if (int'(cnt_inc) >= DEBOUNCE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          state_d = S_HELD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Buffer edit for the accepted key, evaluated only in the single ACT cycle.
  always_comb begin
    buf_d        = buf_q;
    count_d      = count_q;
    chk_d        = chk_q;
    echo_valid_d = 1'b0;
    echo_data_d  = echo_data_q;
    echo_pos_d   = echo_pos_q;
    if (state_q == S_ACT) begin
      if (int'(key_idx) <= 9) begin
        if (int'(base_cnt) < N_BYTES) begin
          buf_d = base_buf;
          for (int i = 0; i < N_BYTES; i++) begin
            if (i == int'(base_cnt)) buf_d[8*i +: 8] = digit_char;
          end
          count_d      = base_cnt + CNT_W'(1);
          chk_d        = 1'b0;
          echo_valid_d = 1'b1;
          echo_data_d  = digit_echo;
          echo_pos_d   = POS_W'(base_cnt);
        end
      end else if (int'(key_idx) == KEY_BS) begin
        if ((count_q != '0) && !chk_q) begin
          for (int i = 0; i < N_BYTES; i++) begin
            if (i == int'(bs_idx)) buf_d[8*i +: 8] = PAD;
          end
          count_d      = bs_idx;
          echo_valid_d = 1'b1;
          echo_data_d  = PAD;
          echo_pos_d   = POS_W'(bs_idx);
        end
      end else if (int'(key_idx) == KEY_EN) begin
        if (count_q != '0) chk_d = 1'b1;
      end
    end
  end

  // Buffer, count, entry-complete flag and echo registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf_q        <= {N_BYTES{PAD}};
      count_q      <= '0;
      chk_q        <= 1'b0;
      echo_valid_q <= 1'b0;
      echo_data_q  <= 8'h00;
      echo_pos_q   <= '0;
    end else begin
      buf_q        <= buf_d;
      count_q      <= count_d;
      chk_q        <= chk_d;
      echo_valid_q <= echo_valid_d;
      echo_data_q  <= echo_data_d;
      echo_pos_q   <= echo_pos_d;
    end
  end

  assign PlainText  = buf_q;
  assign Count      = count_q;
  assign Full       = (int'(count_q) == N_BYTES);
  assign CHK        = chk_q;
  assign Echo_Valid = echo_valid_q;
  assign Echo_Data  = echo_data_q;
  assign Echo_Pos   = echo_pos_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Testbench for keypad_entry_buffer: a 16-byte instance and a 4-byte instance
// share one keypad input. It runs directed vector tables, hand-written corner
// sequences, and random key presses that are checked against a per-press
// behavioural model.
module tb_keypad_entry_buffer;

  localparam int NK  = 12;
  localparam int NB  = 16;
  localparam int NB4 = 4;
  localparam int DB  = 4;
  localparam logic [7:0] PAD = 8'h20;
`ifdef KEYPAD_MASK_EN
  localparam bit MASKED = 1'b1;
`else
  localparam bit MASKED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NK-1:0] keypad;

  logic [8*NB-1:0] pt;
  logic [4:0]      cnt;
  logic            full, chk, ev;
  logic [7:0]      ed;
  logic [3:0]      ep;

  logic [8*NB4-1:0] pt4;
  logic [2:0]       cnt4;
  logic             full4, chk4, ev4;
  logic [7:0]       ed4;
  logic [1:0]       ep4;

  always #5 clk = ~clk;

  keypad_entry_buffer #(.N_KEYS(NK), .N_BYTES(NB), .DEBOUNCE(DB), .PAD(PAD)) dut (
    .CLK(clk), .RST(rst), .Keypad(keypad), .PlainText(pt), .Count(cnt), .Full(full),
    .CHK(chk), .Echo_Valid(ev), .Echo_Data(ed), .Echo_Pos(ep)
  );

  keypad_entry_buffer #(.N_KEYS(NK), .N_BYTES(NB4), .DEBOUNCE(DB), .PAD(PAD)) dut4 (
    .CLK(clk), .RST(rst), .Keypad(keypad), .PlainText(pt4), .Count(cnt4), .Full(full4),
    .CHK(chk4), .Echo_Valid(ev4), .Echo_Data(ed4), .Echo_Pos(ep4)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Echo monitor for both instances.
  int         ecnt [2];
  logic [7:0] last_d [2];
  int         last_p [2];
  int         last_cyc [2];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (ev) begin
      ecnt[0] = ecnt[0] + 1; last_d[0] = ed; last_p[0] = int'(ep); last_cyc[0] = cyc;
    end
    if (ev4) begin
      ecnt[1] = ecnt[1] + 1; last_d[1] = ed4; last_p[1] = int'(ep4); last_cyc[1] = cyc;
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] echo_char(input logic [7:0] c);
    return MASKED ? 8'h2A : c;
  endfunction

  // Behavioural model: one action per accepted press, per instance.
  logic [7:0] mb [2][32];
  int         mc [2];
  bit         mk [2];
  int         nbv [2];
  int         me_n [2];
  logic [7:0] me_d [2];
  int         me_p [2];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 32; i++) mb[u][i] = PAD;
      mc[u] = 0; mk[u] = 1'b0; me_n[u] = 0;
    end
  endtask

  task automatic model_key(input int k);
    for (int u = 0; u < 2; u++) begin
      me_n[u] = 0;
      if (k <= 9) begin
        if (mk[u]) begin
          for (int i = 0; i < 32; i++) mb[u][i] = PAD;
          mc[u] = 0; mk[u] = 1'b0;
        end
        if (mc[u] < nbv[u]) begin
          mb[u][mc[u]] = 8'h30 + 8'(k);
          me_n[u] = 1; me_d[u] = echo_char(8'h30 + 8'(k)); me_p[u] = mc[u];
          mc[u]++;
        end
      end else if (k == NK - 2) begin
        if (mc[u] > 0 && !mk[u]) begin
          mc[u]--;
          mb[u][mc[u]] = PAD;
          me_n[u] = 1; me_d[u] = PAD; me_p[u] = mc[u];
        end
      end else if (k == NK - 1) begin
        if (mc[u] > 0) mk[u] = 1'b1;
      end
    end
  endtask

  function automatic logic [127:0] mpack(input int u);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < nbv[u]; i++) r[8*i +: 8] = mb[u][i];
    return r;
  endfunction

  int start_cyc;
  int e0 [2];

  task automatic do_reset();
    keypad = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Hold key k for 'hold' cycles, then release for 'rel' cycles; sample at the next negedge.
  task automatic press(input int k, input int hold, input int rel);
    @(posedge clk);
    #1;
    keypad = '0;
    keypad[k] = 1'b1;
    start_cyc = cyc;
    e0[0] = ecnt[0];
    e0[1] = ecnt[1];
    repeat (hold) @(posedge clk);
    #1 keypad = '0;
    repeat (rel) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int         key;
    int         hold;
    int         ecount;
    bit         echk;
    int         necho;
    logic [7:0] edata;
    int         epos;
    logic [31:0] elow;
  } vec_t;

  vec_t tbl [14];
  logic [127:0] act_pt;
  int k, h;

  initial begin
    for (int u = 0; u < 2; u++) begin
      ecnt[u] = 0; last_d[u] = 8'h00; last_p[u] = 0; last_cyc[u] = 0;
    end
    nbv[0] = NB;
    nbv[1] = NB4;

    tbl[0]  = '{4,  3, 0, 1'b0, 0, 8'h00, 0, 32'h20202020};
    tbl[1]  = '{11, 5, 0, 1'b0, 0, 8'h00, 0, 32'h20202020};
    tbl[2]  = '{10, 5, 0, 1'b0, 0, 8'h00, 0, 32'h20202020};
    tbl[3]  = '{0,  8, 1, 1'b0, 1, 8'h30, 0, 32'h20202030};
    tbl[4]  = '{10, 5, 0, 1'b0, 1, 8'h20, 0, 32'h20202020};
    tbl[5]  = '{1,  4, 1, 1'b0, 1, 8'h31, 0, 32'h20202031};
    tbl[6]  = '{2,  6, 2, 1'b0, 1, 8'h32, 1, 32'h20203231};
    tbl[7]  = '{3,  5, 3, 1'b0, 1, 8'h33, 2, 32'h20333231};
    tbl[8]  = '{10, 5, 2, 1'b0, 1, 8'h20, 2, 32'h20203231};
    tbl[9]  = '{11, 5, 2, 1'b1, 0, 8'h00, 0, 32'h20203231};
    tbl[10] = '{10, 5, 2, 1'b1, 0, 8'h00, 0, 32'h20203231};
    tbl[11] = '{9,  5, 1, 1'b0, 1, 8'h39, 0, 32'h20202039};
    tbl[12] = '{7,  5, 2, 1'b0, 1, 8'h37, 1, 32'h20203739};
    tbl[13] = '{11, 9, 2, 1'b1, 0, 8'h00, 0, 32'h20203739};

    // Reset state
    keypad = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pt",    pt, {NB{PAD}});
    check("rst_pt4",   128'(pt4), 128'({NB4{PAD}}));
    check("rst_count", 128'(cnt), 0);
    check("rst_full",  128'(full), 0);
    check("rst_chk",   128'(chk), 0);
    check("rst_ev",    128'(ev), 0);
    check("rst_edata", 128'(ed), 0);
    check("rst_epos",  128'(ep), 0);
    #1 rst = 1'b0;
    model_reset();

    // Directed vector table on the 16-byte instance
    for (int r = 0; r < 14; r++) begin
      press(tbl[r].key, tbl[r].hold, 10);
      check($sformatf("tbl%0d_count", r), 128'(cnt), 128'(tbl[r].ecount));
      check($sformatf("tbl%0d_chk", r),   128'(chk), 128'(tbl[r].echk));
      check($sformatf("tbl%0d_full", r),  128'(full), 0);
      check($sformatf("tbl%0d_necho", r), 128'(ecnt[0] - e0[0]), 128'(tbl[r].necho));
      check($sformatf("tbl%0d_low", r),   128'(pt[31:0]), 128'(tbl[r].elow));
      check($sformatf("tbl%0d_high", r),  128'(pt[127:32]), 128'({12{PAD}}));
      if (tbl[r].necho == 1) begin
        check($sformatf("tbl%0d_edata", r), 128'(last_d[0]),
              128'((tbl[r].key <= 9) ? echo_char(tbl[r].edata) : tbl[r].edata));
        check($sformatf("tbl%0d_epos", r), 128'(last_p[0]), 128'(tbl[r].epos));
      end
    end

    // Latency: clean press from reset edits on edge DEBOUNCE+3
    do_reset();
    press(0, 8, 8);
    check("lat_necho", 128'(ecnt[0] - e0[0]), 1);
    check("lat_edge",  128'(last_cyc[0] - start_cyc), 128'(DB + 3));
    check("lat_epos",  128'(last_p[0]), 0);
    check("lat_edata", 128'(last_d[0]), 128'(echo_char(8'h30)));
    check("lat_byte0", 128'(pt[7:0]), 128'(8'h30));
    check("lat_count", 128'(cnt), 1);

    // Four-byte instance: fifth digit is dropped
    do_reset();
    for (int d = 1; d <= 4; d++) press(d, 5, 10);
    check("full4_count", 128'(cnt4), 4);
    check("full4_full",  128'(full4), 1);
    check("full4_pt",    128'(pt4), 128'(32'h34333231));
    press(5, 5, 10);
    check("full4_5th_necho", 128'(ecnt[1] - e0[1]), 0);
    check("full4_5th_pt",    128'(pt4), 128'(32'h34333231));
    check("full4_5th_count", 128'(cnt4), 4);
    check("full16_5th_echo", 128'(ecnt[0] - e0[0]), 1);
    check("full16_notfull",  128'(full), 0);

    // Reset mid-press, then a key still held at deassertion is accepted
    do_reset();
    press(5, 5, 10);
    check("mask_byte0", 128'(pt[7:0]), 128'(8'h35));
    check("mask_edata", 128'(last_d[0]), 128'(echo_char(8'h35)));
    press(6, 5, 10);
    check("pre_epos", 128'(ep), 1);
    @(posedge clk);
    #1 keypad = '0;
    keypad[8] = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_pt",    pt, {NB{PAD}});
    check("midrst_count", 128'(cnt), 0);
    check("midrst_full",  128'(full), 0);
    check("midrst_chk",   128'(chk), 0);
    check("midrst_ev",    128'(ev), 0);
    check("midrst_edata", 128'(ed), 0);
    check("midrst_epos",  128'(ep), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    start_cyc = cyc;
    e0[0] = ecnt[0];
    repeat (12) @(posedge clk);
    #1 keypad = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("postrst_necho", 128'(ecnt[0] - e0[0]), 1);
    check("postrst_edge",  128'(last_cyc[0] - start_cyc), 128'(DB + 3));
    check("postrst_byte0", 128'(pt[7:0]), 128'(8'h38));
    check("postrst_count", 128'(cnt), 1);

    // Random presses against the behavioural model, both instances
    do_reset();
    for (int it = 0; it < 60; it++) begin
      k = int'($urandom_range(0, NK - 1));
      h = int'($urandom_range(1, 9));
      press(k, h, 10);
      if (h >= DB) model_key(k);
      else begin
        me_n[0] = 0;
        me_n[1] = 0;
      end
      for (int u = 0; u < 2; u++) begin
        act_pt = (u == 0) ? pt : 128'(pt4);
        check($sformatf("rnd%0d_u%0d_pt", it, u), act_pt, mpack(u));
        check($sformatf("rnd%0d_u%0d_count", it, u),
              (u == 0) ? 128'(cnt) : 128'(cnt4), 128'(mc[u]));
        check($sformatf("rnd%0d_u%0d_chk", it, u),
              (u == 0) ? 128'(chk) : 128'(chk4), 128'(mk[u]));
        check($sformatf("rnd%0d_u%0d_full", it, u),
              (u == 0) ? 128'(full) : 128'(full4), 128'(mc[u] == nbv[u]));
        check($sformatf("rnd%0d_u%0d_necho", it, u), 128'(ecnt[u] - e0[u]), 128'(me_n[u]));
        if (me_n[u] == 1) begin
          check($sformatf("rnd%0d_u%0d_edata", it, u), 128'(last_d[u]), 128'(me_d[u]));
          check($sformatf("rnd%0d_u%0d_epos", it, u), 128'(last_p[u]), 128'(me_p[u]));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
